// File: rtl/fmul_share_arb.sv
// Round-robin share of one FP32 multiplier between two requesters, with a
// shadow pipeline that routes each product back to its requester and tag.
module fmul_share_arb #(
  parameter int LAT   = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush,
  output logic             mul_valid,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_p,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             busy
);

  logic                        rr;
  logic                        g0, g1, grant;
  logic [LAT:0]                vld_pipe;
  logic [LAT:0]                id_pipe;
  logic [LAT:0][TAG_W-1:0]     tag_pipe;

  // rr=1 hands priority to port 1; a lone requester always wins.
  assign g0    = req0_valid & (~rr | ~req1_valid) & ~flush;
  assign g1    = req1_valid & ~g0 & ~flush;
  assign grant = g0 | g1;

  assign req0_ready = g0;
  assign req1_ready = g1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= 1'b0;
      mul_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      tag_pipe  <= '0;
    end else begin
      if (grant) rr <= g0;
      mul_valid <= grant;
      if (g0) begin
        mul_a <= req0_a;
        mul_b <= req0_b;
      end else if (g1) begin
        mul_a <= req1_a;
        mul_b <= req1_b;
      end
      // Stage LAT lines up with mul_p; flush kills everything behind the tail.
      vld_pipe <= flush ? '0 : {vld_pipe[LAT-1:0], grant};
      id_pipe  <= {id_pipe[LAT-1:0], g1};
      tag_pipe <= {tag_pipe[LAT-1:0], (g1 ? req1_tag : req0_tag)};
    end
  end

  assign rsp0_valid = vld_pipe[LAT] & ~id_pipe[LAT];
  assign rsp1_valid = vld_pipe[LAT] &  id_pipe[LAT];
  assign rsp0_data  = mul_p;
  assign rsp1_data  = mul_p;
  assign rsp0_tag   = tag_pipe[LAT];
  assign rsp1_tag   = tag_pipe[LAT];
  // Stage 0 valid always equals mul_valid, so the shadow bits cover both.
  assign busy       = |vld_pipe;

endmodule

// File: tb/tb_fmul_share_arb.sv
// Directed + random bench for fmul_share_arb against a queue-based response
// model and a behavioural FP32 multiplier stub.
module tb_fmul_share_arb;
  localparam int LAT   = 2;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0, flush = 1'b0;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic             mul_valid;
  logic [31:0]      mul_a, mul_b, mul_p;
  logic             rsp0_valid, rsp1_valid, busy;
  logic [31:0]      rsp0_data, rsp1_data;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;

  fmul_share_arb #(.LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_tag(req1_tag),
    .flush(flush), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // FP32 multiply via double precision (exact product), then RNE to single.
  // Operands are kept in the normal range so no subnormal/inf handling.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    real         ra, rb;
    logic [63:0] d;
    logic [31:0] r;
    ra = $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
    rb = $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
    d  = $realtobits(ra * rb);
    r  = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    if (d[28:0] > 29'h10000000 || (d[28:0] == 29'h10000000 && d[29])) r = r + 32'd1;
    return r;
  endfunction

  // Multiplier stub: LAT-cycle pipeline behind the registered operands.
  logic [LAT-1:0][31:0] p_pipe;
  always @(posedge clk) begin
    p_pipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) p_pipe[i] <= p_pipe[i-1];
  end
  assign mul_p = p_pipe[LAT-1];

  typedef struct {
    int               due;
    bit               port;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;

  exp_t        q[$];
  bit          m_prio1;
  bit          m_prev_g;
  logic [31:0] m_a, m_b;
  int          cyc;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] pa0, pb0, pa1, pb1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic set_rand();
    pa0 = rnd_op(); pb0 = rnd_op(); pa1 = rnd_op(); pb1 = rnd_op();
  endtask

  // One clock cycle: drive at negedge, check, advance the model.
  task automatic cycle(input bit v0, input bit v1, input bit fl,
                       input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1);
    bit   e0, e1, ev0, ev1, hit;
    exp_t e;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1; flush = fl;
    req0_a = pa0; req0_b = pb0; req1_a = pa1; req1_b = pb1;
    req0_tag = t0; req1_tag = t1;
    #1;
    e0 = v0 && !fl && (!v1 || !m_prio1);
    e1 = v1 && !fl && !e0;
    chk("ready0", 32'(req0_ready), 32'(e0));
    chk("ready1", 32'(req1_ready), 32'(e1));
    chk("mul_valid", 32'(mul_valid), 32'(m_prev_g));
    if (m_prev_g) begin
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
    end
    chk("busy", 32'(busy), 32'(q.size() != 0));
    hit = (q.size() != 0) && (q[0].due == cyc);
    ev0 = hit && !q[0].port;
    ev1 = hit &&  q[0].port;
    chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    if (hit) begin
      e = q.pop_front();
      chk(e.port ? "rsp1_data" : "rsp0_data", e.port ? rsp1_data : rsp0_data, e.data);
      chk(e.port ? "rsp1_tag" : "rsp0_tag", 32'(e.port ? rsp1_tag : rsp0_tag), 32'(e.tag));
    end
    if (fl) q.delete();
    if (e0 || e1) begin
      m_a = e1 ? pa1 : pa0;
      m_b = e1 ? pb1 : pb0;
      q.push_back('{due: cyc + LAT + 1, port: e1, tag: (e1 ? t1 : t0), data: fmul(m_a, m_b)});
      m_prio1 = e0;
    end
    m_prev_g = e0 || e1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset mid-cycle; outputs must drop without a clock edge.
  task automatic reset_dut();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mul_valid", 32'(mul_valid), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    q.delete();
    m_prio1 = 1'b0;
    m_prev_g = 1'b0;
  endtask

  initial begin
    cyc = 0; m_prio1 = 1'b0; m_prev_g = 1'b0; m_a = '0; m_b = '0;
    set_rand();
    reset_dut();

    // Single op: 2.0 * 3.0 with tag 5 on port 0.
    pa0 = 32'h40000000; pb0 = 32'h40400000;
    cycle(1'b1, 1'b0, 1'b0, 5'd5, 5'd0);
    idle(3);
    chk("single_data", rsp0_data, 32'h40C00000);
    chk("single_tag", 32'(rsp0_tag), 32'd5);
    idle(2);

    // Contention straight after reset: strict alternation starting at port 0.
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      set_rand();
      cycle(1'b1, 1'b1, 1'b0, 5'(i), 5'(16 + i));
    end
    idle(LAT + 2);

    // Solo streaming on port 1 with tags 1..4.
    for (int i = 1; i <= 4; i++) begin
      set_rand();
      cycle(1'b0, 1'b1, 1'b0, '0, 5'(i));
    end
    idle(LAT + 2);

    // Flush one cycle after the third acceptance; requests still pending.
    for (int i = 0; i < 3; i++) begin
      set_rand();
      cycle(i[0], !i[0], 1'b0, 5'(i), 5'(i + 8));
    end
    set_rand();
    cycle(1'b1, 1'b1, 1'b1, 5'd30, 5'd31);
    idle(LAT + 3);

    // Reset with two ops in flight, then a contested grant.
    set_rand(); cycle(1'b0, 1'b1, 1'b0, '0, 5'd3);
    set_rand(); cycle(1'b1, 1'b0, 1'b0, 5'd4, '0);
    reset_dut();
    set_rand(); cycle(1'b1, 1'b1, 1'b0, 5'd7, 5'd9);
    idle(LAT + 3);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      set_rand();
      cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
            5'($urandom), 5'($urandom));
    end
    idle(LAT + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
